quot_rem: RTL

Sequential 64-bit integer divider producing quotient and remainder with truncate-toward-zero semantics, in both signed (`longint`) and unsigned (`longint unsigned`) modes. It is the inverse companion of the combinational `mul`/`mulW` arithmetic blocks and is used wherever generated designs need `quot`/`rem` on 64-bit values. Operands enter and results leave over valid/ready handshakes, and the divider retires one quotient bit per clock.

---
 rtl/quot_rem.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/quot_rem.sv
// Sequential restoring radix-2 divider: one quotient bit per clock, signed or unsigned,
// truncate-toward-zero quotient and remainder, valid/ready on both sides.
module quot_rem #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
    magnitude = neg ? (-x) : x;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] nq_q, nq_d;      // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] oq_q, oq_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic             div0_q, div0_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic             neg_n_s, neg_d_s;
  logic [WIDTH:0]   rem_sh_s, diff_s;

  assign neg_n_s  = i_signed & i_n[WIDTH-1];
  assign neg_d_s  = i_signed & i_d[WIDTH-1];
  assign rem_sh_s = {rem_q, nq_q[WIDTH-1]};
  assign diff_s   = rem_sh_s - {1'b0, dv_q};

  // Next-state and datapath update for the accept / iterate / finish / handshake flow
  always_comb begin
    state_d   = state_q;
    nq_d      = nq_q;
    rem_d     = rem_q;
    dv_d      = dv_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    oq_d      = oq_q;
    or_d      = or_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          nq_d      = magnitude(i_n, neg_n_s);
          dv_d      = magnitude(i_d, neg_d_s);
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = neg_n_s ^ neg_d_s;
          neg_rem_d = neg_n_s;
          zero_d    = (i_d == '0);
          div0_d    = 1'b0;
          state_d   = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (zero_q) begin
          // nq still holds |n|, so re-applying the sign restores the raw dividend
          oq_d    = '1;
          or_d    = magnitude(nq_q, neg_rem_q);
          div0_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          oq_d    = magnitude(nq_q, neg_quo_q);
          or_d    = magnitude(rem_q, neg_rem_q);
          state_d = DONE;
        end else begin
          if (!diff_s[WIDTH]) begin
            rem_d = diff_s[WIDTH-1:0];
            nq_d  = {nq_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh_s[WIDTH-1:0];
            nq_d  = {nq_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      nq_q      <= '0;
      rem_q     <= '0;
      dv_q      <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      oq_q      <= '0;
      or_q      <= '0;
      div0_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      nq_q      <= nq_d;
      rem_q     <= rem_d;
      dv_q      <= dv_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      oq_q      <= oq_d;
      or_q      <= or_d;
      div0_q    <= div0_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_q     = oq_q;
  assign o_r     = or_q;
  assign o_div0  = div0_q;

endmodule
